scoreboard_hazard_unit: RTL and testbench

Parametrised successor to the in-order issue hazard scoreboard for the RV32I pipeline. Sits at the decode/issue boundary.
- Per architectural register, tracks a pending write and a per-register countdown of cycles until the result commits.
- Raises stall on RAW/WAW hazards and kill on control redirects.
- Latency is selected per instruction class instead of a fixed shift pattern.

---
 rtl/scoreboard_pkg.sv | 50 +++++
 rtl/sb_reg_counter.sv | 51 +++++
 rtl/scoreboard_hazard_unit.sv | 119 +++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the issue hazard scoreboard: latency classes,
// default class latencies and the RV32I opcode-to-class table used by decode.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    LC_ALU  = 2'd0,
    LC_LOAD = 2'd1,
    LC_CSR  = 2'd2,
    LC_MUL  = 2'd3
  } lat_class_e;

  localparam int DEF_LAT_ALU  = 2;
  localparam int DEF_LAT_LOAD = 3;
  localparam int DEF_LAT_CSR  = 3;
  localparam int DEF_LAT_MUL  = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic lat_class_e class_of(input logic [6:0] opcode, input logic [6:0] funct7);
    lat_class_e c;
    case (opcode)
      OPC_LOAD:   c = LC_LOAD;
      OPC_SYSTEM: c = LC_CSR;
      OPC_OP:     c = (funct7 == F7_MULDIV) ? LC_MUL : LC_ALU;
      default:    c = LC_ALU;
    endcase
    return c;
  endfunction

  function automatic int lat_of(input lat_class_e c);
    int l;
    case (c)
      LC_ALU:  l = DEF_LAT_ALU;
      LC_LOAD: l = DEF_LAT_LOAD;
      LC_CSR:  l = DEF_LAT_CSR;
      LC_MUL:  l = DEF_LAT_MUL;
      default: l = DEF_LAT_ALU;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// One architectural register's pending-write countdown (and producer class when
// SCOREBOARD_FWD_EN is defined). A load overrides the per-cycle decrement.
module sb_reg_counter
  import scoreboard_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
`ifdef SCOREBOARD_FWD_EN
  input  logic [1:0]    load_cls,
  output logic          last,
  output logic [1:0]    cls,
`endif
  output logic          busy
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {CW{1'b0}}) begin
      cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

`ifdef SCOREBOARD_FWD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cls <= 2'd0;
    end else if (load) begin
      cls <= load_cls;
    end else begin
      cls <= cls;
    end
  end

  // Final countdown cycle: the result is on the execute bypass this cycle.
  assign last = (cnt == {{(CW-1){1'b0}}, 1'b1});
`endif

  assign busy = (cnt != {CW{1'b0}});

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// In-order issue hazard scoreboard: per-register commit countdowns, RAW/WAW stall
// and redirect kill window. Optional macro SCOREBOARD_FWD_EN enables ALU forwarding.
module scoreboard_hazard_unit
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int LAT_ALU     = DEF_LAT_ALU,
  parameter int LAT_LOAD    = DEF_LAT_LOAD,
  parameter int LAT_CSR     = DEF_LAT_CSR,
  parameter int LAT_MUL     = DEF_LAT_MUL,
  parameter int KILL_CYCLES = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic [AW-1:0]       rd,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic                wr_rd,
  input  logic [1:0]          lat_class,
  input  logic                btaken,
  input  logic                exception,
  input  logic                discard,
  output logic                stall,
  output logic                kill,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int MAX_LAT_A = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
  localparam int MAX_LAT_B = (LAT_CSR > LAT_MUL) ? LAT_CSR : LAT_MUL;
  localparam int MAX_LAT   = (MAX_LAT_A > MAX_LAT_B) ? MAX_LAT_A : MAX_LAT_B;
  localparam int CW        = $clog2(MAX_LAT + 1);
  localparam int KW        = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

  logic [CW-1:0]       lat_val;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] blocked;
  logic                load_en;
  logic                raw;
  logic                waw;
  logic                redirect;
  logic [KW-1:0]       kcnt;

  always_comb begin
    lat_val = CW'(LAT_ALU);
    case (lat_class_e'(lat_class))
      LC_ALU:  lat_val = CW'(LAT_ALU);
      LC_LOAD: lat_val = CW'(LAT_LOAD);
      LC_CSR:  lat_val = CW'(LAT_CSR);
      LC_MUL:  lat_val = CW'(LAT_MUL);
      default: lat_val = CW'(LAT_ALU);
    endcase
  end

  assign load_en = issue_fire & wr_rd & (rd != {AW{1'b0}});

  assign busy[0]    = 1'b0;
  assign blocked[0] = 1'b0;

  // x0 is never tracked, so counters exist for registers 1..NUM_REGS-1 only.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
`ifdef SCOREBOARD_FWD_EN
    logic       last;
    logic [1:0] cls;

    sb_reg_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_en & (rd == AW'(r))),
      .load_val (lat_val),
      .load_cls (lat_class),
      .last     (last),
      .cls      (cls),
      .busy     (busy[r])
    );

    assign blocked[r] = busy[r] & ~(last & (cls == LC_ALU));
`else
    sb_reg_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_en & (rd == AW'(r))),
      .load_val (lat_val),
      .busy     (busy[r])
    );

    assign blocked[r] = busy[r];
`endif
  end

  assign raw = (use_rs1 & blocked[rs1] & (rs1 != {AW{1'b0}}))
             | (use_rs2 & blocked[rs2] & (rs2 != {AW{1'b0}}));
  assign waw = wr_rd & busy[rd] & (rd != {AW{1'b0}});

  assign redirect = (btaken | exception) & ~discard;

  // A new redirect reloads the window rather than adding to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt <= {KW{1'b0}};
    end else if (redirect) begin
      kcnt <= KW'(KILL_CYCLES - 1);
    end else if (kcnt != {KW{1'b0}}) begin
      kcnt <= kcnt - {{(KW-1){1'b0}}, 1'b1};
    end else begin
      kcnt <= kcnt;
    end
  end

  assign kill       = redirect | (kcnt != {KW{1'b0}});
  assign stall      = issue_valid & (raw | waw) & ~kill;
  assign issue_fire = issue_valid & ~stall & ~kill;
  assign busy_vec   = busy;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Randomized self-checking bench for scoreboard_hazard_unit; the reference model
// tracks each register's ready cycle and the last killed cycle as plain integers.
module tb_scoreboard_hazard_unit;

  localparam int NR = 32;
  localparam int K  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [4:0]    rs1, rs2, rd;
  logic          use_rs1, use_rs2, wr_rd;
  logic [1:0]    lat_class;
  logic          btaken, exception, discard;
  logic          stall, kill, issue_fire;
  logic [NR-1:0] busy_vec;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_at [NR];
  int cls_m    [NR];
  int kill_until = -1;
  int stall_seen = 0;
  int fire_cyc   = -1;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  scoreboard_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .use_rs1     (use_rs1),
    .use_rs2     (use_rs2),
    .wr_rd       (wr_rd),
    .lat_class   (lat_class),
    .btaken      (btaken),
    .exception   (exception),
    .discard     (discard),
    .stall       (stall),
    .kill        (kill),
    .issue_fire  (issue_fire),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_m(input int c);
    case (c)
      0:       return 2;
      1:       return 3;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit busy_m(input int r);
    return (r != 0) && (cyc < ready_at[r]);
  endfunction

  function automatic bit blocks_m(input int r);
    return busy_m(r) && !(FWD && cls_m[r] == 0 && cyc == ready_at[r] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      ready_at[i] = 0;
      cls_m[i]    = 0;
    end
    kill_until = -1;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic u1, input logic u2, input logic w, input logic [1:0] lc,
                       input logic bt, input logic ex, input logic dis, input logic r);
    bit e_redirect, e_kill, e_stall, e_fire, e_raw, e_waw;
    logic [NR-1:0] e_busy;
    @(negedge clk);
    issue_valid = v; rs1 = a; rs2 = b; rd = d;
    use_rs1 = u1; use_rs2 = u2; wr_rd = w; lat_class = lc;
    btaken = bt; exception = ex; discard = dis; rst = r;
    #1;
    e_raw      = (u1 && blocks_m(int'(a))) || (u2 && blocks_m(int'(b)));
    e_waw      = w && busy_m(int'(d));
    e_redirect = (bt || ex) && !dis;
    e_kill     = e_redirect || (cyc <= kill_until);
    e_stall    = v && (e_raw || e_waw) && !e_kill;
    e_fire     = v && !e_stall && !e_kill;
    for (int i = 0; i < NR; i++) e_busy[i] = busy_m(i);
    check_eq("stall", 64'(stall), 64'(e_stall));
    check_eq("kill", 64'(kill), 64'(e_kill));
    check_eq("issue_fire", 64'(issue_fire), 64'(e_fire));
    check_eq("busy_vec", 64'(busy_vec), 64'(e_busy));
    if (stall === 1'b1) stall_seen++;
    if (issue_fire === 1'b1 && fire_cyc < 0) fire_cyc = cyc;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_fire && w && d != 5'd0) begin
        ready_at[d] = cyc + 1 + lat_m(int'(lc));
        cls_m[d]    = int'(lc);
      end
      if (e_redirect) kill_until = cyc + K - 1;
    end
    cyc++;
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    int base;
    rst = 1'b1; issue_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; wr_rd = 1'b0; lat_class = 2'd0;
    btaken = 1'b0; exception = 1'b0; discard = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    idle(1'b1);
    check_eq("reset_busy_vec", 64'(busy_vec), 64'd0);
    idle(1'b0);

    // ALU producer rd=5 then consumer rs1=5
    stall_seen = 0; fire_cyc = -1;
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    fire_cyc = -1; base = cyc;
    repeat (3) drive(1'b1, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("alu_raw_stalls", 64'(stall_seen), FWD ? 64'd1 : 64'd2);
    check_eq("alu_raw_fire_cycle", 64'(fire_cyc - base), FWD ? 64'd1 : 64'd2);
    repeat (2) idle(1'b0);

    // LOAD producer rd=7 then consumer rs2=7: three stall cycles
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stall_seen = 0;
    repeat (4) drive(1'b1, 5'd0, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("load_raw_stalls", 64'(stall_seen), 64'd3);
    repeat (4) idle(1'b0);

    // x0 is never tracked
    stall_seen = 0;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("x0_no_stall", 64'(stall_seen), 64'd0);
    check_eq("x0_busy", 64'(busy_vec[0]), 64'd0);
    repeat (4) idle(1'b0);

    // Redirect, extended window, discard
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) idle(1'b0);

    // Reset mid-operation clears a pending LOAD
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    fire_cyc = -1; base = cyc;
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_reset_fire", 64'(fire_cyc == base), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 23) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
